spsram_arb_ctrl: RTL and testbench
==================================

SPSRAM_ARB_CTRL -- requirements
Module: spsram_arb_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 19, the SRAM word-address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 128, the SRAM data width; byte-lane count is DATA_WIDTH/8.
REQ-003 SHALL provide parameter INIT_EN, default 1, which enables zero-fill of the whole array after reset.
REQ-004 SHALL have exactly one clock and one reset: pll_core_cpuclk, input, 1 bit, the sole clock, all state on its rising edge; pad_cpu_rst_b, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL provide, for each port n in {0,1}: pn_req in 1 (request); pn_we in 1 (1 = write); pn_addr in ADDR_WIDTH; pn_wdata in DATA_WIDTH; pn_wstrb in DATA_WIDTH/8 (1 = write byte); pn_gnt out 1; pn_rvalid out 1; pn_rdata out DATA_WIDTH.
REQ-006 SHALL provide the SRAM side: sram_a out ADDR_WIDTH; sram_cen out 1, active-low; sram_d out DATA_WIDTH; sram_wen out DATA_WIDTH/8, active-low per byte; sram_q in DATA_WIDTH.
REQ-007 SHALL provide init_done, output, 1 bit, high once the controller accepts requests.

Function
REQ-008 SHALL implement FSM states INIT and RUN; on reset it enters INIT if INIT_EN=1, otherwise RUN.
REQ-009 In INIT, SHALL drive sram_cen=0, sram_wen=all 0, sram_d=0, sram_a=init counter; the counter starts at 0 and increments once per cycle.
REQ-010 In the INIT cycle where the counter equals 2^ADDR_WIDTH-1, SHALL write that address and then go to RUN; INIT takes exactly 2^ADDR_WIDTH cycles.
REQ-011 In INIT, SHALL hold p0_gnt=p1_gnt=0 and init_done=0 regardless of requests.
REQ-012 In RUN, init_done SHALL be 1.
REQ-013 In RUN, SHALL grant at most one port per cycle, combinationally in the same cycle as the request.
REQ-014 Arbitration: only one pn_req high -> grant that port; both high -> grant the port not recorded in last_gnt; last_gnt resets to 1, so port 0 wins the first contention.
REQ-015 last_gnt SHALL update to the granted port on every grant, including uncontended grants.
REQ-016 On a grant, SHALL drive sram_cen=0 and sram_a=addr of the granted port.
REQ-017 For a granted write, SHALL drive sram_d=wdata and sram_wen=~wstrb.
REQ-018 For a granted read, SHALL drive sram_wen=all 1.
REQ-019 A granted write with wstrb=0 SHALL still assert sram_cen=0 and SHALL produce no rvalid.
REQ-020 With no grant in RUN, SHALL drive sram_cen=1, sram_wen=all 1, and sram_a and sram_d held at their last driven values.
REQ-021 Read latency SHALL be 1 cycle: pn_rvalid=1 in the cycle after port n's read grant, for exactly one cycle.
REQ-022 pn_rdata SHALL equal sram_q while pn_rvalid=1; otherwise its value is unspecified.
REQ-023 Back-to-back reads SHALL be accepted every cycle, and alternating grants SHALL produce alternating rvalids.
REQ-024 The requester SHALL hold req, we, addr, wdata and wstrb stable until gnt; the controller does not register request fields.
REQ-025 Read after write to the same address in consecutive cycles SHALL return the new data; no hazard logic is needed.

Reset
REQ-026 While pad_cpu_rst_b=0, SHALL force: p0_gnt=p1_gnt=0, p0_rvalid=p1_rvalid=0, init_done=0, sram_cen=1, sram_wen=all 1, sram_a=0, sram_d=0, init counter=0, last_gnt=1.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity and drop any pending rvalid.
REQ-028 After reset release, SHALL restart from REQ-008.

Verification
REQ-029 INIT, ADDR_WIDTH=4, INIT_EN=1: release reset -> 16 zero-writes to addresses 0..15, init_done rises on cycle 17, and a read of address 5 returns 0.
REQ-030 Contention: after init, p0 and p1 request every cycle -> grants P0,P1,P0,P1; each read's rvalid appears one cycle later on the matching port only.
REQ-031 Byte write: write addr 3 with 0xFF.. and wstrb=0xFFFF, then 0x00.. with wstrb=0x0001, then read -> rdata=0xFF..FF00 and sram_wen=0xFFFE on the second write.
REQ-032 Request during INIT: p0_req=1 at cycle 3 -> no gnt until init_done, then gnt in the first RUN cycle.
REQ-033 Reset mid-read: assert reset in the cycle after a p1 read grant -> p1_rvalid stays 0 and INIT restarts at address 0.
REQ-034 INIT_EN=0: init_done=1 on the first cycle after reset, and a single p1 read is granted the same cycle.

Source files
------------

// File: rtl/spsram_arb_ctrl.sv
// rtl/spsram_arb_ctrl.sv - two-port round-robin arbiter for a single-port SRAM with zero-fill init
module spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 128,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wstrb,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wstrb,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  output logic [DATA_WIDTH/8-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0]   sram_q,
  output logic                    init_done
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic                    last_gnt_q;
  logic [1:0]              rd_pend_q;

  logic                    gnt0, gnt1;
  logic                    cen_d;
  logic [STRB_WIDTH-1:0]   wen_d;
  logic [ADDR_WIDTH-1:0]   a_d;
  logic [DATA_WIDTH-1:0]   d_d;

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= INIT_EN ? ST_INIT : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    cen_d   = 1'b1;
    wen_d   = '1;
    a_d     = a_q;
    d_d     = d_q;
    if (state_q == ST_INIT) begin
      cen_d = 1'b0;
      wen_d = '0;
      a_d   = init_cnt_q;
      d_d   = '0;
      if (init_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end else begin
      // On contention the port that did not win last time gets the slot.
      gnt0 = p0_req & (~p1_req | last_gnt_q);
      gnt1 = p1_req & (~p0_req | ~last_gnt_q);
      if (gnt0) begin
        cen_d = 1'b0;
        a_d   = p0_addr;
        if (p0_we) begin
          d_d   = p0_wdata;
          wen_d = ~p0_wstrb;
        end
      end else if (gnt1) begin
        cen_d = 1'b0;
        a_d   = p1_addr;
        if (p1_we) begin
          d_d   = p1_wdata;
          wen_d = ~p1_wstrb;
        end
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      init_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 2'b00;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      if (state_q == ST_INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
      end
      if (gnt0 | gnt1) begin
        last_gnt_q <= gnt1;
      end
      rd_pend_q <= {gnt1 & ~p1_we, gnt0 & ~p0_we};
      a_q       <= a_d;
      d_q       <= d_d;
    end
  end

  // Combinational outputs are forced to their idle values while reset is held.
  assign p0_gnt    = pad_cpu_rst_b & gnt0;
  assign p1_gnt    = pad_cpu_rst_b & gnt1;
  assign p0_rvalid = rd_pend_q[0];
  assign p1_rvalid = rd_pend_q[1];
  assign p0_rdata  = sram_q;
  assign p1_rdata  = sram_q;
  assign sram_cen  = ~pad_cpu_rst_b | cen_d;
  assign sram_wen  = pad_cpu_rst_b ? wen_d : '1;
  assign sram_a    = pad_cpu_rst_b ? a_d : '0;
  assign sram_d    = pad_cpu_rst_b ? d_d : '0;
  assign init_done = pad_cpu_rst_b & (state_q == ST_RUN);

endmodule

// File: tb/tb_spsram_arb_ctrl.sv
// tb/tb_spsram_arb_ctrl.sv - self-checking bench for spsram_arb_ctrl
module tb_spsram_arb_ctrl;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, b_rst_n;
  logic p0_req, p0_we, p0_gnt, p0_rvalid, p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p0_addr, p1_addr, sram_a;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, sram_d, sram_q;
  logic [SW-1:0] p0_wstrb, p1_wstrb, sram_wen;
  logic sram_cen, init_done;

  logic b_p0_req, b_p0_we, b_p0_gnt, b_p0_rvalid, b_p1_req, b_p1_we, b_p1_gnt, b_p1_rvalid;
  logic [AW-1:0] b_p0_addr, b_p1_addr, b_sram_a;
  logic [DW-1:0] b_p0_wdata, b_p1_wdata, b_p0_rdata, b_p1_rdata, b_sram_d, b_q;
  logic [SW-1:0] b_p0_wstrb, b_p1_wstrb, b_sram_wen;
  logic b_sram_cen, b_init_done;

  spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q),
    .init_done(init_done)
  );

  spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b0)) dut_noinit (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(b_rst_n),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata), .p0_wstrb(b_p0_wstrb),
    .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata), .p1_wstrb(b_p1_wstrb),
    .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
    .sram_a(b_sram_a), .sram_cen(b_sram_cen), .sram_d(b_sram_d), .sram_wen(b_sram_wen), .sram_q(b_q),
    .init_done(b_init_done)
  );

  // SRAM array behind the controller, pre-filled with garbage so zero-fill is observable.
  logic fill_en = 1'b1;
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end else if (!sram_cen) begin
      if (&sram_wen) sram_q <= mem[sram_a];
      else for (int b = 0; b < SW; b++) if (!sram_wen[b]) mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
    end
  end

  int total = 0;
  int bad = 0;
  logic [DW-1:0] ref_mem [16];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %b want %b", nm, act, exp); end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %h want %h", nm, act, exp); end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++) if (s[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
  endtask

  typedef struct { logic r0; logic r1; logic e0; logic e1; } vec_t;
  vec_t vec [11];

  int lastw, w;
  logic pend0, pend1, new0, new1;
  logic [DW-1:0] exp0, exp1, hold_d;
  logic [AW-1:0] pa;

  initial begin
    vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vec[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    rst_n = 1'b0; b_rst_n = 1'b0; idle();
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 4'd7;
    b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = '0; b_p0_wdata = '0; b_p0_wstrb = '0;
    b_p1_req = 1'b1; b_p1_we = 1'b0; b_p1_addr = 4'd6; b_p1_wdata = '0; b_p1_wstrb = '0;
    b_q = {4{32'hA5C3_0F96}};
    tick(); tick();
    fill_en = 1'b0;
    @(negedge clk);
    chk1("rst_g0", p0_gnt, 1'b0);
    chk1("rst_g1", p1_gnt, 1'b0);
    chk1("rst_rv0", p0_rvalid, 1'b0);
    chk1("rst_rv1", p1_rvalid, 1'b0);
    chk1("rst_done", init_done, 1'b0);
    chk1("rst_cen", sram_cen, 1'b1);
    chkw("rst_wen", DW'(sram_wen), DW'(16'hFFFF));
    chkw("rst_a", DW'(sram_a), '0);
    chkw("rst_d", sram_d, '0);

    tick(); idle(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin p0_req = 1'b1; p0_addr = 4'd5; end
      @(negedge clk);
      chkw("init_a", DW'(sram_a), DW'(i));
      chk1("init_cen", sram_cen, 1'b0);
      chkw("init_wen", DW'(sram_wen), '0);
      chkw("init_d", sram_d, '0);
      chk1("init_done", init_done, 1'b0);
      chk1("init_g0", p0_gnt, 1'b0);
      tick();
    end
    @(negedge clk);
    chk1("run_done", init_done, 1'b1);
    chk1("run_g0", p0_gnt, 1'b1);
    chkw("run_a", DW'(sram_a), DW'(5));
    chk1("run_cen", sram_cen, 1'b0);
    chkw("run_wen", DW'(sram_wen), DW'(16'hFFFF));
    tick(); idle();
    @(negedge clk);
    chk1("rd5_rv0", p0_rvalid, 1'b1);
    chkw("rd5_data", p0_rdata, '0);
    chk1("rd5_rv1", p1_rvalid, 1'b0);

    pend0 = 1'b0; pend1 = 1'b0; pa = 4'd5;
    for (int k = 0; k < 11; k++) begin
      tick();
      p0_req = vec[k].r0; p1_req = vec[k].r1; p0_addr = 4'd1; p1_addr = 4'd2;
      @(negedge clk);
      if (vec[k].e0) pa = 4'd1;
      else if (vec[k].e1) pa = 4'd2;
      chk1("vec_g0", p0_gnt, vec[k].e0);
      chk1("vec_g1", p1_gnt, vec[k].e1);
      chk1("vec_cen", sram_cen, ~(vec[k].e0 | vec[k].e1));
      chkw("vec_a", DW'(sram_a), DW'(pa));
      chk1("vec_rv0", p0_rvalid, pend0);
      chk1("vec_rv1", p1_rvalid, pend1);
      pend0 = vec[k].e0; pend1 = vec[k].e1;
    end
    tick(); idle();
    @(negedge clk);
    chk1("vec_rv0_end", p0_rvalid, pend0);
    chk1("vec_rv1_end", p1_rvalid, pend1);

    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 4'd3; p0_wdata = '1; p0_wstrb = '1;
    @(negedge clk);
    chk1("bw1_g0", p0_gnt, 1'b1);
    chkw("bw1_wen", DW'(sram_wen), '0);
    chkw("bw1_d", sram_d, '1);
    ref_write(4'd3, '1, '1);
    tick();
    p0_wdata = '0; p0_wstrb = 16'h0001;
    @(negedge clk);
    chk1("bw2_g0", p0_gnt, 1'b1);
    chkw("bw2_wen", DW'(sram_wen), DW'(16'hFFFE));
    chk1("bw2_rv0", p0_rvalid, 1'b0);
    ref_write(4'd3, '0, 16'h0001);
    tick();
    p0_we = 1'b0;
    @(negedge clk);
    chk1("bw3_g0", p0_gnt, 1'b1);
    chkw("bw3_wen", DW'(sram_wen), DW'(16'hFFFF));
    tick(); idle();
    @(negedge clk);
    chk1("bw_rv0", p0_rvalid, 1'b1);
    chkw("bw_rdata", p0_rdata, {{15{8'hFF}}, 8'h00});
    chk1("hold_cen", sram_cen, 1'b1);
    chkw("hold_a", DW'(sram_a), DW'(3));
    chkw("hold_d", sram_d, '0);
    tick();
    hold_d = {$urandom(), $urandom(), $urandom(), $urandom()};
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'd9; p1_wdata = hold_d; p1_wstrb = '0;
    @(negedge clk);
    chk1("z_g1", p1_gnt, 1'b1);
    chk1("z_cen", sram_cen, 1'b0);
    chkw("z_wen", DW'(sram_wen), DW'(16'hFFFF));
    tick(); idle();
    @(negedge clk);
    chk1("z_rv1", p1_rvalid, 1'b0);
    chkw("z_hold_a", DW'(sram_a), DW'(9));
    chkw("z_hold_d", sram_d, hold_d);

    lastw = 1; pend0 = 1'b0; pend1 = 1'b0; new0 = 1'b1; new1 = 1'b1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (new0) begin
        p0_req = ($urandom_range(0, 3) != 0); p0_we = ($urandom_range(0, 1) == 1);
        p0_addr = AW'($urandom_range(0, 15)); p0_wstrb = SW'($urandom_range(0, 65535));
        p0_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (new1) begin
        p1_req = ($urandom_range(0, 3) != 0); p1_we = ($urandom_range(0, 1) == 1);
        p1_addr = AW'($urandom_range(0, 15)); p1_wstrb = SW'($urandom_range(0, 65535));
        p1_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (p0_req && p1_req) w = 1 - lastw;
      else if (p0_req) w = 0;
      else if (p1_req) w = 1;
      else w = -1;
      @(negedge clk);
      chk1("rnd_g0", p0_gnt, w == 0);
      chk1("rnd_g1", p1_gnt, w == 1);
      chk1("rnd_rv0", p0_rvalid, pend0);
      chk1("rnd_rv1", p1_rvalid, pend1);
      if (pend0) chkw("rnd_rd0", p0_rdata, exp0);
      if (pend1) chkw("rnd_rd1", p1_rdata, exp1);
      if (w >= 0) chkw("rnd_a", DW'(sram_a), DW'(w == 0 ? p0_addr : p1_addr));
      pend0 = (w == 0) && !p0_we;
      pend1 = (w == 1) && !p1_we;
      exp0 = ref_mem[p0_addr];
      exp1 = ref_mem[p1_addr];
      if (w == 0 && p0_we) ref_write(p0_addr, p0_wdata, p0_wstrb);
      if (w == 1 && p1_we) ref_write(p1_addr, p1_wdata, p1_wstrb);
      if (w >= 0) lastw = w;
      new0 = !p0_req || (w == 0);
      new1 = !p1_req || (w == 1);
    end
    tick(); idle();
    @(negedge clk);
    chk1("rnd_rv0_end", p0_rvalid, pend0);
    chk1("rnd_rv1_end", p1_rvalid, pend1);
    if (pend0) chkw("rnd_rd0_end", p0_rdata, exp0);
    if (pend1) chkw("rnd_rd1_end", p1_rdata, exp1);

    tick();
    p1_req = 1'b1; p1_addr = 4'd4;
    @(negedge clk);
    chk1("mr_g1", p1_gnt, 1'b1);
    tick(); idle(); rst_n = 1'b0;
    @(negedge clk);
    chk1("mr_rv1", p1_rvalid, 1'b0);
    chk1("mr_cen", sram_cen, 1'b1);
    chk1("mr_done", init_done, 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chkw("mr_a0", DW'(sram_a), '0);
    chk1("mr_cen0", sram_cen, 1'b0);
    chk1("mr_rv1b", p1_rvalid, 1'b0);
    tick();
    @(negedge clk);
    chkw("mr_a1", DW'(sram_a), DW'(1));

    chk1("ni_rst_g1", b_p1_gnt, 1'b0);
    chk1("ni_rst_done", b_init_done, 1'b0);
    tick(); b_rst_n = 1'b1;
    @(negedge clk);
    chk1("ni_done", b_init_done, 1'b1);
    chk1("ni_g1", b_p1_gnt, 1'b1);
    chk1("ni_cen", b_sram_cen, 1'b0);
    chkw("ni_a", DW'(b_sram_a), DW'(6));
    tick(); b_p1_req = 1'b0;
    @(negedge clk);
    chk1("ni_rv1", b_p1_rvalid, 1'b1);
    chk1("ni_rv0", b_p0_rvalid, 1'b0);
    chkw("ni_rd1", b_p1_rdata, {4{32'hA5C3_0F96}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
